cam_requester: RTL and testbench
================================

Name: cam_requester

Overview:
- Initiator-side controller for the 32-entry CAM. It is the block that drives the CAM's read, write and search inputs and collects its read and search outputs.
- Accepts one command at a time on a valid/ready request channel. It sequences the command onto the CAM pins, waits for the CAM result or a timeout, and returns one response per command on a valid/ready response channel.
- Sits between the lookup client logic and the CAM instance.

Parameters:
- DATA_W, 32, CAM data width.
- IDX_W, 5, CAM index width (2**IDX_W entries).
- TIMEOUT, 4, cycles to wait after issue for read_valid/search_valid before declaring a miss (range 1..15).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  requester can accept a command.
- req_op_i  in  2  cam_op_e: 0 READ, 1 WRITE, 2 SEARCH, 3 reserved.
- req_index_i  in  IDX_W  index for READ/WRITE.
- req_data_i  in  DATA_W  write data (WRITE) or key (SEARCH).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  client accepts response.
- rsp_op_o  out  2  op of the completed command.
- rsp_hit_o  out  1  1 = CAM returned valid; 0 = timeout/miss; always 1 for WRITE.
- rsp_data_o  out  DATA_W  READ value; 0 for other ops.
- rsp_index_o  out  IDX_W  SEARCH match index; 0 for other ops.
- read_enable_o  out  1  to CAM read_enable_i.
- read_index_o  out  IDX_W  to CAM read_index_i.
- write_enable_o  out  1  to CAM write_enable_i.
- write_index_o  out  IDX_W  to CAM write_index_i.
- write_data_o  out  DATA_W  to CAM write_data_i.
- search_enable_o  out  1  to CAM search_enable_i.
- search_data_o  out  DATA_W  to CAM search_data_i.
- read_valid_i  in  1  from CAM read_valid_o.
- read_value_i  in  DATA_W  from CAM read_value_o.
- search_valid_i  in  1  from CAM search_valid_o.
- search_index_i  in  IDX_W  from CAM search_index_o.

Behaviour:
- Reset (rst_i low, asynchronous):
  - FSM goes to IDLE.
  - All CAM-side outputs are 0.
  - rsp_valid_o=0, rsp_* = 0, req_ready_o=0 while reset is asserted.
  - Reset asserted mid-command drops the command; no response is produced.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch op/index/data and go to ISSUE.
  - Reserved op (3) goes directly to RESP with hit=0.
- ISSUE (exactly 1 cycle):
  - Drive exactly one enable high, with its index/data registered and stable.
  - WRITE goes to RESP with hit=1. The CAM write completes on that edge, so a following READ sees the new data.
  - READ and SEARCH go to WAIT, with the timeout counter cleared to 0.
- WAIT:
  - All enables are 0.
  - READ: on read_valid_i=1, capture read_value_i, set hit=1, go to RESP.
  - SEARCH: on search_valid_i=1, capture search_index_i, set hit=1, go to RESP.
  - The counter increments each cycle without the matching valid. When it reaches TIMEOUT-1, go to RESP with hit=0 and data/index=0.
  - The non-matching valid is ignored; e.g. read_valid_i is ignored during a SEARCH.
  - Valids arriving in IDLE, ISSUE or RESP are ignored.
- RESP:
  - rsp_valid_o=1, with rsp_* held stable until rsp_ready_i.
  - On handshake go to IDLE.
  - req_ready_o=0 in RESP; there is no command overlap.
- Latency:
  - WRITE: req handshake to rsp_valid = 2 cycles.
  - READ/SEARCH with CAM result 1 cycle after enable: 3 cycles.
  - Timeout case: 2+TIMEOUT cycles.
- Throughput: at most one command per 3 cycles (WRITE); no pipelining.
- All outputs are registered; there are no combinational paths from req_* or CAM inputs to any output.

Optional Feature:
- Macro CAM_REQ_STATS_EN.
- When defined:
  - Adds ports stat_hit_o (16, out), stat_miss_o (16, out) and stat_clr_i (1, in).
  - stat_hit_o counts READ/SEARCH responses with hit=1; stat_miss_o counts those with hit=0.
  - Counters increment on the rsp handshake, saturate at 16'hFFFF, reset to 0, and clear synchronously on stat_clr_i. Clear wins over a same-cycle increment.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cam_pkg holds:
  - cam_op_e enum (READ, WRITE, SEARCH, RSVD).
  - CAM_DATA_W=32 and CAM_IDX_W=5.
  - cam_req_t struct (op, index, data) and cam_rsp_t struct (op, hit, data, index).
  - FSM state enum.
- No sub-module is needed. The optional stats counters may be a small sub-module cam_req_stats, instantiated under the macro.

Test Plan:
- WRITE idx 5 data 32'hDEADBEEF -> one-cycle write_enable_o with write_index_o=5 and write_data_o=32'hDEADBEEF; rsp 2 cycles later with op=WRITE, hit=1.
- READ idx 5 after that write, CAM model returns read_valid 1 cycle after enable -> rsp op=READ, hit=1, data=32'hDEADBEEF, 3 cycles after req handshake.
- SEARCH key 32'hDEADBEEF -> search_enable_o pulse; CAM returns index 5 -> rsp hit=1, index=5. SEARCH key 32'h12345678 with no CAM valid -> rsp hit=0, index=0 after 2+TIMEOUT=6 cycles.
- Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_* stay stable, req_ready_o=0, and a new req_valid_i is not accepted until the handshake completes.
- Drive rst_i low during WAIT of a READ -> all CAM outputs 0 and rsp_valid_o=0 immediately; after release the FSM is in IDLE with req_ready_o=1, and a late read_valid_i is ignored.
- With CAM_REQ_STATS_EN defined: 3 hits, 2 misses -> stat_hit_o=3, stat_miss_o=2; pulse stat_clr_i -> both 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types for the CAM requester: op codes, request/response records, FSM states.
package cam_pkg;

  localparam int CAM_DATA_W = 32;
  localparam int CAM_IDX_W  = 5;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_SEARCH = 2'd2,
    OP_RSVD   = 2'd3
  } cam_op_e;

  typedef struct packed {
    cam_op_e                 op;
    logic [CAM_IDX_W-1:0]    index;
    logic [CAM_DATA_W-1:0]   data;
  } cam_req_t;

  typedef struct packed {
    cam_op_e                 op;
    logic                    hit;
    logic [CAM_DATA_W-1:0]   data;
    logic [CAM_IDX_W-1:0]    index;
  } cam_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } cam_req_state_e;

endpackage

// File: rtl/cam_req_stats.sv
// Saturating hit/miss counters for completed READ/SEARCH responses; clear beats increment.
module cam_req_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        hit_inc_i,
  input  logic        miss_inc_i,
  output logic [15:0] hit_o,
  output logic [15:0] miss_o
);

  logic [15:0] r_hit;
  logic [15:0] r_miss;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hit  <= 16'd0;
      r_miss <= 16'd0;
    end else if (clr_i) begin
      r_hit  <= 16'd0;
      r_miss <= 16'd0;
    end else begin
      if (hit_inc_i && (r_hit != 16'hFFFF))
        r_hit <= r_hit + 16'd1;
      if (miss_inc_i && (r_miss != 16'hFFFF))
        r_miss <= r_miss + 16'd1;
    end
  end

  assign hit_o  = r_hit;
  assign miss_o = r_miss;

endmodule

// File: rtl/cam_requester.sv
// One-command-at-a-time CAM initiator: issue, wait for result or timeout, respond.
// Optional hit/miss statistics enabled by CAM_REQ_STATS_EN.
module cam_requester
  import cam_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 5,
  parameter int TIMEOUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [IDX_W-1:0]  req_index_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_op_o,
  output logic              rsp_hit_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [IDX_W-1:0]  rsp_index_o,
  output logic              read_enable_o,
  output logic [IDX_W-1:0]  read_index_o,
  output logic              write_enable_o,
  output logic [IDX_W-1:0]  write_index_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic              search_enable_o,
  output logic [DATA_W-1:0] search_data_o,
  input  logic              read_valid_i,
  input  logic [DATA_W-1:0] read_value_i,
  input  logic              search_valid_i,
  input  logic [IDX_W-1:0]  search_index_i
`ifdef CAM_REQ_STATS_EN
  ,
  output logic [15:0]       stat_hit_o,
  output logic [15:0]       stat_miss_o,
  input  logic              stat_clr_i
`endif
);

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  cam_req_state_e    r_state;
  cam_op_e           r_op;
  logic [3:0]        r_cnt;
  logic              r_req_ready;
  logic              r_rd_en;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_wr_en;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [DATA_W-1:0] r_wr_dat;
  logic              r_sr_en;
  logic [DATA_W-1:0] r_sr_dat;
  logic              r_rsp_valid;
  cam_op_e           r_rsp_op;
  logic              r_rsp_hit;
  logic [DATA_W-1:0] r_rsp_data;
  logic [IDX_W-1:0]  r_rsp_index;

  cam_op_e w_op;
  assign w_op = cam_op_e'(req_op_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_READ;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_idx    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_dat    <= '0;
      r_sr_en     <= 1'b0;
      r_sr_dat    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= OP_READ;
      r_rsp_hit   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_index <= '0;
    end else begin
      // Enables are single-cycle pulses; only the accept branch raises one.
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_sr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid_i && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_op        <= w_op;
            case (w_op)
              OP_READ: begin
                r_rd_en  <= 1'b1;
                r_rd_idx <= req_index_i;
                r_state  <= ST_ISSUE;
              end
              OP_WRITE: begin
                r_wr_en  <= 1'b1;
                r_wr_idx <= req_index_i;
                r_wr_dat <= req_data_i;
                r_state  <= ST_ISSUE;
              end
              OP_SEARCH: begin
                r_sr_en  <= 1'b1;
                r_sr_dat <= req_data_i;
                r_state  <= ST_ISSUE;
              end
              default: begin
                r_state     <= ST_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_op    <= w_op;
                r_rsp_hit   <= 1'b0;
                r_rsp_data  <= '0;
                r_rsp_index <= '0;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          r_cnt <= 4'd0;
          if (r_op == OP_WRITE) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= r_op;
            r_rsp_hit   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_index <= '0;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if ((r_op == OP_READ) && read_valid_i) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= r_op;
            r_rsp_hit   <= 1'b1;
            r_rsp_data  <= read_value_i;
            r_rsp_index <= '0;
          end else if ((r_op == OP_SEARCH) && search_valid_i) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= r_op;
            r_rsp_hit   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_index <= search_index_i;
          end else if (r_cnt == TO_LAST) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= r_op;
            r_rsp_hit   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_index <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= OP_READ;
            r_rsp_hit   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_index <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o     = r_req_ready;
  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_op_o        = r_rsp_op;
  assign rsp_hit_o       = r_rsp_hit;
  assign rsp_data_o      = r_rsp_data;
  assign rsp_index_o     = r_rsp_index;
  assign read_enable_o   = r_rd_en;
  assign read_index_o    = r_rd_idx;
  assign write_enable_o  = r_wr_en;
  assign write_index_o   = r_wr_idx;
  assign write_data_o    = r_wr_dat;
  assign search_enable_o = r_sr_en;
  assign search_data_o   = r_sr_dat;

`ifdef CAM_REQ_STATS_EN
  logic w_lookup_fire;
  assign w_lookup_fire = r_rsp_valid && rsp_ready_i &&
                         ((r_rsp_op == OP_READ) || (r_rsp_op == OP_SEARCH));

  cam_req_stats u_stats (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (stat_clr_i),
    .hit_inc_i  (w_lookup_fire && r_rsp_hit),
    .miss_inc_i (w_lookup_fire && !r_rsp_hit),
    .hit_o      (stat_hit_o),
    .miss_o     (stat_miss_o)
  );
`endif

endmodule

// File: tb/tb_cam_requester.sv
// Directed bench for cam_requester with a small behavioural CAM responding one cycle after enable.
module tb_cam_requester;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready_o;
  logic [1:0]  req_op;
  logic [4:0]  req_index;
  logic [31:0] req_data;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [1:0]  rsp_op_o;
  logic        rsp_hit_o;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_index_o;
  logic        read_enable_o;
  logic [4:0]  read_index_o;
  logic        write_enable_o;
  logic [4:0]  write_index_o;
  logic [31:0] write_data_o;
  logic        search_enable_o;
  logic [31:0] search_data_o;
  logic        read_valid_i;
  logic [31:0] read_value_i;
  logic        search_valid_i;
  logic [4:0]  search_index_i;
`ifdef CAM_REQ_STATS_EN
  logic [15:0] stat_hit_o;
  logic [15:0] stat_miss_o;
  logic        stat_clr;
`endif

  int vec = 0;
  int err = 0;

  // Behavioural CAM plus bench-forced stray valids.
  logic        cam_mute = 1'b0;
  logic [31:0] mem [32];
  logic [31:0] mem_vld = '0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rval = '0;
  logic        m_sv = 1'b0;
  logic [4:0]  m_si = '0;
  logic        x_rv = 1'b0;
  logic [31:0] x_rval = '0;
  logic        x_sv = 1'b0;
  logic [4:0]  x_si = '0;

  assign read_valid_i   = m_rv | x_rv;
  assign read_value_i   = x_rv ? x_rval : m_rval;
  assign search_valid_i = m_sv | x_sv;
  assign search_index_i = x_sv ? x_si : m_si;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_rv <= 1'b0;
    m_sv <= 1'b0;
    if (write_enable_o) begin
      mem[write_index_o]     <= write_data_o;
      mem_vld[write_index_o] <= 1'b1;
    end
    if (read_enable_o && !cam_mute) begin
      m_rv   <= 1'b1;
      m_rval <= mem[read_index_o];
    end
    if (search_enable_o && !cam_mute) begin
      for (int i = 31; i >= 0; i--) begin
        if (mem_vld[i] && (mem[i] == search_data_o)) begin
          m_sv <= 1'b1;
          m_si <= 5'(i);
        end
      end
    end
  end

  cam_requester dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready_o),
    .req_op_i        (req_op),
    .req_index_i     (req_index),
    .req_data_i      (req_data),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready),
    .rsp_op_o        (rsp_op_o),
    .rsp_hit_o       (rsp_hit_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_index_o     (rsp_index_o),
    .read_enable_o   (read_enable_o),
    .read_index_o    (read_index_o),
    .write_enable_o  (write_enable_o),
    .write_index_o   (write_index_o),
    .write_data_o    (write_data_o),
    .search_enable_o (search_enable_o),
    .search_data_o   (search_data_o),
    .read_valid_i    (read_valid_i),
    .read_value_i    (read_value_i),
    .search_valid_i  (search_valid_i),
    .search_index_i  (search_index_i)
`ifdef CAM_REQ_STATS_EN
    ,
    .stat_hit_o      (stat_hit_o),
    .stat_miss_o     (stat_miss_o),
    .stat_clr_i      (stat_clr)
`endif
  );

  // Present a request; returns #1 after the handshake edge.
  task automatic send_req(input logic [1:0] op, input logic [4:0] idx,
                          input logic [31:0] dat, output bit ok);
    ok        = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_data  = dat;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (req_ready_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Latency in cycles from the handshake edge to the first cycle rsp_valid is seen; -1 if none.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid_o) lat = -1;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (req_ready_o !== 1'b0) begin err++; $display("FAIL reset_req_ready got %b want 0", req_ready_o); end
    vec++; if ({rsp_valid_o, rsp_hit_o, rsp_op_o, rsp_data_o, rsp_index_o} !== '0) begin
      err++; $display("FAIL reset_rsp got v=%b h=%b op=%0d d=%h i=%0d want all 0", rsp_valid_o, rsp_hit_o, rsp_op_o, rsp_data_o, rsp_index_o); end
    vec++; if ({read_enable_o, write_enable_o, search_enable_o, read_index_o, write_index_o, write_data_o, search_data_o} !== '0) begin
      err++; $display("FAIL reset_cam_outputs got re=%b we=%b se=%b want all 0", read_enable_o, write_enable_o, search_enable_o); end
    rst_i = 1'b1;
    @(posedge clk); #1;
    vec++; if (req_ready_o !== 1'b1) begin err++; $display("FAIL post_reset_ready got %b want 1", req_ready_o); end
  endtask

  task automatic test_write();
    bit ok; int lat;
    send_req(2'd1, 5'd5, 32'hDEADBEEF, ok);
    vec++; if (!ok) begin err++; $display("FAIL write_accept got no handshake want handshake"); end
    vec++; if ({write_enable_o, write_index_o, write_data_o, read_enable_o, search_enable_o} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'b00}) begin
      err++; $display("FAIL write_issue got we=%b idx=%0d d=%h re=%b se=%b want 1/5/deadbeef/0/0", write_enable_o, write_index_o, write_data_o, read_enable_o, search_enable_o); end
    wait_rsp(1, lat);
    vec++; if (lat !== 2) begin err++; $display("FAIL write_latency got %0d want 2", lat); end
    vec++; if (write_enable_o !== 1'b0) begin err++; $display("FAIL write_pulse_width got we=%b want 0", write_enable_o); end
    vec++; if ({rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o} !== {2'd1, 1'b1, 32'd0, 5'd0}) begin
      err++; $display("FAIL write_rsp got op=%0d h=%b d=%h i=%0d want 1/1/0/0", rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o); end
    ack_rsp();
    vec++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin err++; $display("FAIL write_ack got v=%b rdy=%b want 0/1", rsp_valid_o, req_ready_o); end
  endtask

  task automatic test_read();
    bit ok; int lat;
    send_req(2'd0, 5'd5, 32'h0, ok);
    vec++; if ({ok, read_enable_o, read_index_o, write_enable_o, search_enable_o} !== {1'b1, 1'b1, 5'd5, 2'b00}) begin
      err++; $display("FAIL read_issue got ok=%b re=%b idx=%0d want 1/1/5", ok, read_enable_o, read_index_o); end
    wait_rsp(1, lat);
    vec++; if (lat !== 3) begin err++; $display("FAIL read_latency got %0d want 3", lat); end
    vec++; if ({rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o} !== {2'd0, 1'b1, 32'hDEADBEEF, 5'd0}) begin
      err++; $display("FAIL read_rsp got op=%0d h=%b d=%h i=%0d want 0/1/deadbeef/0", rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o); end
    ack_rsp();
  endtask

  task automatic test_search();
    bit ok; int lat;
    send_req(2'd2, 5'd0, 32'hDEADBEEF, ok);
    vec++; if ({ok, search_enable_o, search_data_o, read_enable_o, write_enable_o} !== {1'b1, 1'b1, 32'hDEADBEEF, 2'b00}) begin
      err++; $display("FAIL search_issue got ok=%b se=%b key=%h want 1/1/deadbeef", ok, search_enable_o, search_data_o); end
    wait_rsp(1, lat);
    vec++; if (lat !== 3) begin err++; $display("FAIL search_latency got %0d want 3", lat); end
    vec++; if ({rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o} !== {2'd2, 1'b1, 32'd0, 5'd5}) begin
      err++; $display("FAIL search_rsp got op=%0d h=%b d=%h i=%0d want 2/1/0/5", rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o); end
    ack_rsp();
    // Key not present: CAM stays silent, requester times out.
    send_req(2'd2, 5'd0, 32'h12345678, ok);
    wait_rsp(1, lat);
    vec++; if (lat !== 6) begin err++; $display("FAIL search_miss_latency got %0d want 6", lat); end
    vec++; if ({rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o} !== {2'd2, 1'b0, 32'd0, 5'd0}) begin
      err++; $display("FAIL search_miss_rsp got op=%0d h=%b d=%h i=%0d want 2/0/0/0", rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o); end
    ack_rsp();
  endtask

  task automatic test_timeout_ignore();
    bit ok; int lat;
    cam_mute = 1'b1;
    send_req(2'd0, 5'd5, 32'h0, ok);
    @(posedge clk); #1;
    x_sv = 1'b1; x_si = 5'd9;
    @(posedge clk); #1;
    x_sv = 1'b0;
    wait_rsp(3, lat);
    cam_mute = 1'b0;
    vec++; if (lat !== 6) begin err++; $display("FAIL read_timeout_latency got %0d want 6", lat); end
    vec++; if ({rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o} !== {2'd0, 1'b0, 32'd0, 5'd0}) begin
      err++; $display("FAIL read_timeout_rsp got op=%0d h=%b d=%h i=%0d want 0/0/0/0", rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o); end
    ack_rsp();
  endtask

  task automatic test_reserved();
    bit ok; int lat;
    send_req(2'd3, 5'd4, 32'hFFFFFFFF, ok);
    vec++; if ({read_enable_o, write_enable_o, search_enable_o} !== 3'b000) begin
      err++; $display("FAIL rsvd_no_enable got re=%b we=%b se=%b want 000", read_enable_o, write_enable_o, search_enable_o); end
    wait_rsp(1, lat);
    vec++; if ({lat == 1, rsp_op_o, rsp_hit_o, rsp_data_o, rsp_index_o} !== {1'b1, 2'd3, 1'b0, 32'd0, 5'd0}) begin
      err++; $display("FAIL rsvd_rsp got lat=%0d op=%0d h=%b want 1/3/0", lat, rsp_op_o, rsp_hit_o); end
    ack_rsp();
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    send_req(2'd1, 5'd7, 32'hA5A5A5A5, ok);
    wait_rsp(1, lat);
    req_valid = 1'b1; req_op = 2'd0; req_index = 5'd7; req_data = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vec++; if ({rsp_valid_o, rsp_op_o, rsp_hit_o, rsp_data_o, req_ready_o, read_enable_o} !== {1'b1, 2'd1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
        err++; $display("FAIL bp_hold_%0d got v=%b op=%0d h=%b rdy=%b re=%b want 1/1/1/0/0", c, rsp_valid_o, rsp_op_o, rsp_hit_o, req_ready_o, read_enable_o); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vec++; if ({rsp_valid_o, req_ready_o, read_enable_o} !== 3'b010) begin
      err++; $display("FAIL bp_release got v=%b rdy=%b re=%b want 0/1/0", rsp_valid_o, req_ready_o, read_enable_o); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vec++; if ({read_enable_o, read_index_o} !== {1'b1, 5'd7}) begin
      err++; $display("FAIL bp_next_accept got re=%b idx=%0d want 1/7", read_enable_o, read_index_o); end
    wait_rsp(1, lat);
    vec++; if ({lat == 3, rsp_hit_o, rsp_data_o} !== {1'b1, 1'b1, 32'hA5A5A5A5}) begin
      err++; $display("FAIL bp_readback got lat=%0d h=%b d=%h want 3/1/a5a5a5a5", lat, rsp_hit_o, rsp_data_o); end
    ack_rsp();
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; bit stray;
    cam_mute = 1'b1;
    send_req(2'd0, 5'd5, 32'h0, ok);
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    vec++; if ({read_enable_o, write_enable_o, search_enable_o, read_index_o, rsp_valid_o, req_ready_o} !== '0) begin
      err++; $display("FAIL midreset_outputs got re=%b idx=%0d v=%b rdy=%b want all 0", read_enable_o, read_index_o, rsp_valid_o, req_ready_o); end
    cam_mute = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    x_rv = 1'b1; x_rval = 32'hFFFF0000;
    @(posedge clk); #1;
    x_rv = 1'b0;
    vec++; if (req_ready_o !== 1'b1) begin err++; $display("FAIL midreset_idle got rdy=%b want 1", req_ready_o); end
    stray = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid_o) stray = 1'b1;
      @(posedge clk); #1;
    end
    vec++; if (stray !== 1'b0) begin err++; $display("FAIL midreset_no_rsp got stray response want none"); end
    send_req(2'd0, 5'd5, 32'h0, ok);
    wait_rsp(1, lat);
    vec++; if ({lat == 3, rsp_hit_o, rsp_data_o} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
      err++; $display("FAIL midreset_recover got lat=%0d h=%b d=%h want 3/1/deadbeef", lat, rsp_hit_o, rsp_data_o); end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    bit ok; int lat;
    send_req(2'd1, 5'd3, 32'h0BADF00D, ok);
    wait_rsp(1, lat);
    ack_rsp();
    send_req(2'd0, 5'd3, 32'h0, ok);
    wait_rsp(1, lat);
    vec++; if ({ok, lat == 3, rsp_hit_o, rsp_data_o} !== {1'b1, 1'b1, 1'b1, 32'h0BADF00D}) begin
      err++; $display("FAIL b2b_readback got ok=%b lat=%0d h=%b d=%h want 1/3/1/0badf00d", ok, lat, rsp_hit_o, rsp_data_o); end
    ack_rsp();
  endtask

`ifdef CAM_REQ_STATS_EN
  task automatic test_stats();
    bit ok; int lat;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    vec++; if ({stat_hit_o, stat_miss_o} !== 32'd0) begin
      err++; $display("FAIL stats_clear0 got hit=%0d miss=%0d want 0/0", stat_hit_o, stat_miss_o); end
    send_req(2'd0, 5'd5, 32'h0, ok);        wait_rsp(1, lat); ack_rsp();
    send_req(2'd2, 5'd0, 32'hDEADBEEF, ok); wait_rsp(1, lat); ack_rsp();
    send_req(2'd0, 5'd3, 32'h0, ok);        wait_rsp(1, lat); ack_rsp();
    send_req(2'd2, 5'd0, 32'h12345678, ok); wait_rsp(1, lat); ack_rsp();
    cam_mute = 1'b1;
    send_req(2'd0, 5'd5, 32'h0, ok);        wait_rsp(1, lat); ack_rsp();
    cam_mute = 1'b0;
    send_req(2'd1, 5'd9, 32'h1, ok);        wait_rsp(1, lat); ack_rsp();
    vec++; if ({stat_hit_o, stat_miss_o} !== {16'd3, 16'd2}) begin
      err++; $display("FAIL stats_count got hit=%0d miss=%0d want 3/2", stat_hit_o, stat_miss_o); end
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    vec++; if ({stat_hit_o, stat_miss_o} !== 32'd0) begin
      err++; $display("FAIL stats_clear got hit=%0d miss=%0d want 0/0", stat_hit_o, stat_miss_o); end
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_op = 2'd0; req_index = 5'd0; req_data = 32'd0;
    rsp_ready = 1'b0;
`ifdef CAM_REQ_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_search();
    test_timeout_ignore();
    test_reserved();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef CAM_REQ_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
